// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit datapath.
// Fetch FSM encoding and PC reset/step defaults live here.
package cpu_pkg;

    localparam int WORD_W = 16;
    localparam int PC_STEP = 2;
    localparam logic [WORD_W-1:0] RESET_VECTOR = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/pc_adder.sv
// Plain modulo-2^W adder shared by the PC incrementer
// and the branch-target adder.
module pc_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch FSM with a req/ack
// handshake to instruction memory.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR,
    parameter int                PC_STEP      = cpu_pkg::PC_STEP
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] NEXT_PC,
    input  logic              STALL,
    input  logic              HALT_REQ,
    input  logic              IMEM_ACK,
    input  logic [WORD_W-1:0] IMEM_DATA,
    output logic [WORD_W-1:0] PC,
    output logic [WORD_W-1:0] PC_PLUS,
    output logic [WORD_W-1:0] IMEM_ADDR,
    output logic              IMEM_REQ,
    output logic [WORD_W-1:0] IR,
    output logic              IR_VALID,
    output logic              FAULT,
    output logic              HALTED
);

    fetch_state_t state;
    logic         halt_pend;

    pc_adder #(.W(WORD_W)) u_inc (
        .a   (PC),
        .b   (WORD_W'(PC_STEP)),
        .sum (PC_PLUS)
    );

    assign IMEM_ADDR = PC;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            PC        <= RESET_VECTOR;
            IR        <= '0;
            IR_VALID  <= 1'b0;
            IMEM_REQ  <= 1'b0;
            FAULT     <= 1'b0;
            HALTED    <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            IR_VALID <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (HALT_REQ || halt_pend) begin
                        state  <= ST_HALT;
                        HALTED <= 1'b1;
                    end else if (!STALL) begin
                        state    <= ST_FETCH;
                        IMEM_REQ <= 1'b1;
                    end
                end
                ST_FETCH, ST_WAIT: begin
                    if (IMEM_ACK) begin
                        if (NEXT_PC[0]) begin
                            state    <= ST_FAULT;
                            FAULT    <= 1'b1;
                            IMEM_REQ <= 1'b0;
                        end else begin
                            IR       <= IMEM_DATA;
                            IR_VALID <= 1'b1;
                            PC       <= NEXT_PC;
                            // A pending halt passes through IDLE so the
                            // IR_VALID pulse never lands in HALT.
                            if (HALT_REQ || halt_pend) begin
                                state     <= ST_IDLE;
                                IMEM_REQ  <= 1'b0;
                                halt_pend <= 1'b1;
                            end else if (STALL) begin
                                state    <= ST_IDLE;
                                IMEM_REQ <= 1'b0;
                            end else begin
                                state <= ST_FETCH;
                            end
                        end
                    end else begin
                        state <= ST_WAIT;
                        if (HALT_REQ) halt_pend <= 1'b1;
                    end
                end
                ST_HALT, ST_FAULT: begin
                end
                default: begin
                    state    <= ST_IDLE;
                    IMEM_REQ <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed fetch,
// wait, branch, wrap, fault, halt and reset scenarios.
module tb_pc_fetch_unit;
    import cpu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        STALL = 1'b0;
    logic        HALT_REQ = 1'b0;
    logic        IMEM_ACK = 1'b0;
    logic [15:0] NEXT_PC, IMEM_DATA;
    logic [15:0] PC, PC_PLUS, IMEM_ADDR, IR;
    logic        IMEM_REQ, IR_VALID, FAULT, HALTED;

    logic        sel = 1'b0;
    logic [15:0] tgt = 16'h0000;

    assign NEXT_PC   = sel ? tgt : PC_PLUS;
    assign IMEM_DATA = IMEM_ADDR ^ 16'h5A00;

    always #5 CLK = ~CLK;

    pc_fetch_unit dut (
        .CLK       (CLK),
        .RST       (RST),
        .NEXT_PC   (NEXT_PC),
        .STALL     (STALL),
        .HALT_REQ  (HALT_REQ),
        .IMEM_ACK  (IMEM_ACK),
        .IMEM_DATA (IMEM_DATA),
        .PC        (PC),
        .PC_PLUS   (PC_PLUS),
        .IMEM_ADDR (IMEM_ADDR),
        .IMEM_REQ  (IMEM_REQ),
        .IR        (IR),
        .IR_VALID  (IR_VALID),
        .FAULT     (FAULT),
        .HALTED    (HALTED)
    );

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_fetch(input logic [15:0] ir, input logic [15:0] pc);
        exp_t e;
        e.ir = ir;
        e.pc = pc;
        sb.push_back(e);
    endtask

    // Monitor: every IR_VALID pulse must match the oldest expectation.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (IR_VALID) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ir_valid got ir %h pc %h want none",
                         IR, PC);
            end else begin
                e = sb.pop_front();
                chk("sb_ir", IR, e.ir);
                chk("sb_pc", PC, e.pc);
            end
        end
    end

    initial begin
        int n;
        tick();
        tick();
        chk("rst_pc", PC, 16'h0000);
        chk("rst_ir", IR, 16'h0000);
        chk("rst_irv", 16'(IR_VALID), 16'd0);
        chk("rst_req", 16'(IMEM_REQ), 16'd0);
        chk("rst_fault", 16'(FAULT), 16'd0);
        chk("rst_halted", 16'(HALTED), 16'd0);
        RST = 1'b0;

        // zero-wait sequential fetch
        tick();
        chk("first_req", 16'(IMEM_REQ), 16'd1);
        chk("first_addr", IMEM_ADDR, 16'h0000);
        IMEM_ACK = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_fetch(16'h5A00 | 16'(2 * i), 16'(2 * i + 2));
            tick();
            chk("seq_pc", PC, 16'(2 * i + 2));
        end

        // three wait states at 0010
        IMEM_ACK = 1'b0;
        chk("wait_req0", 16'(IMEM_REQ), 16'd1);
        chk("wait_addr0", IMEM_ADDR, 16'h0010);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("wait_req", 16'(IMEM_REQ), 16'd1);
            chk("wait_addr", IMEM_ADDR, 16'h0010);
        end
        expect_fetch(16'h5A10, 16'h0012);
        IMEM_ACK = 1'b1;
        tick();
        chk("wait_pc", PC, 16'h0012);

        // taken branch
        sel = 1'b1;
        tgt = 16'h0100;
        expect_fetch(16'h5A12, 16'h0100);
        tick();
        chk("br_pc", PC, 16'h0100);
        chk("br_addr", IMEM_ADDR, 16'h0100);
        sel = 1'b0;
        expect_fetch(16'h5B00, 16'h0102);
        tick();
        chk("br_next_pc", PC, 16'h0102);

        // wrap FFFE -> 0000
        sel = 1'b1;
        tgt = 16'hFFFE;
        expect_fetch(16'h5B02, 16'hFFFE);
        tick();
        chk("wrap_pc", PC, 16'hFFFE);
        chk("wrap_plus", PC_PLUS, 16'h0000);
        sel = 1'b0;
        expect_fetch(16'hA5FE, 16'h0000);
        tick();
        chk("wrap_pc0", PC, 16'h0000);
        chk("wrap_nofault", 16'(FAULT), 16'd0);

        // misaligned target
        sel = 1'b1;
        tgt = 16'h0101;
        tick();
        chk("flt_fault", 16'(FAULT), 16'd1);
        chk("flt_pc", PC, 16'h0000);
        chk("flt_req", 16'(IMEM_REQ), 16'd0);
        sel = 1'b0;
        tick();
        tick();
        chk("flt_sticky", 16'(FAULT), 16'd1);
        chk("flt_req_hold", 16'(IMEM_REQ), 16'd0);
        chk("flt_pc_hold", PC, 16'h0000);

        RST = 1'b1;
        IMEM_ACK = 1'b0;
        tick();
        RST = 1'b0;
        chk("flt_clear", 16'(FAULT), 16'd0);

        // halt requested during WAIT
        tick();
        tick();
        chk("h_wait_req", 16'(IMEM_REQ), 16'd1);
        HALT_REQ = 1'b1;
        tick();
        HALT_REQ = 1'b0;
        tick();
        expect_fetch(16'h5A00, 16'h0002);
        IMEM_ACK = 1'b1;
        tick();
        IMEM_ACK = 1'b0;
        n = 0;
        while (!HALTED && n < 4) begin
            tick();
            n++;
        end
        chk("h_halted", 16'(HALTED), 16'd1);
        chk("h_req", 16'(IMEM_REQ), 16'd0);
        tick();
        tick();
        chk("h_pc", PC, 16'h0002);
        chk("h_ir", IR, 16'h5A00);

        // reset during WAIT, late ACK ignored
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        tick();
        chk("r_wait_req", 16'(IMEM_REQ), 16'd1);
        RST = 1'b1;
        tick();
        chk("r_pc", PC, 16'h0000);
        chk("r_req", 16'(IMEM_REQ), 16'd0);
        RST = 1'b0;
        STALL = 1'b1;
        IMEM_ACK = 1'b1;
        tick();
        tick();
        chk("late_pc", PC, 16'h0000);
        chk("late_req", 16'(IMEM_REQ), 16'd0);
        chk("late_ir", IR, 16'h0000);

        // stall never suppresses a capture
        STALL = 1'b0;
        expect_fetch(16'h5A00, 16'h0002);
        tick();
        tick();
        expect_fetch(16'h5A02, 16'h0004);
        STALL = 1'b1;
        tick();
        chk("st_pc", PC, 16'h0004);
        chk("st_req", 16'(IMEM_REQ), 16'd0);
        tick();
        chk("st_pc_hold", PC, 16'h0004);
        chk("st_ir_hold", IR, 16'h5A02);

        tick();
        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
